mult_div_unit_iter: RTL and testbench
=====================================

Name: mult_div_unit_iter

Overview:
- Iterative 1-bit-per-cycle shift-add multiplier for MULT/MULTU, with HI/LO architectural registers. Lives in the EX stage.
- Its `busy` output drives the hazard unit's `multiply` input, so any later instruction stalls in ID until HI/LO are valid.
- Also services MTHI/MTLO writes and supplies HI/LO to the MFHI/MFLO datapath mux.

Parameters:
- WIDTH, 32, operand width. HI and LO are WIDTH each; the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- start  input  1  EX-stage MULT/MULTU issue; sampled on the rising edge.
- sign_mode  input  1  1 = MULT (two's complement), 0 = MULTU.
- src_a  input  WIDTH  multiplicand (rs value).
- src_b  input  WIDTH  multiplier (rt value).
- wr_hi  input  1  MTHI write enable.
- wr_lo  input  1  MTLO write enable.
- wr_data  input  WIDTH  MTHI/MTLO data.
- busy  output  1  to hazard unit `multiply`; combinational (start & state==IDLE) | (state!=IDLE).
- done  output  1  registered one-cycle pulse when HI/LO update from a multiply.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, accumulator/multiplicand/multiplier=0, hi=0, lo=0, done=0. busy follows its equation, so it equals start while reset is held.
- States: IDLE, RUN, FINISH.
- IDLE, start=1 at edge E0:
  - If sign_mode=1, latch |src_a| and |src_b| and set neg_flag=src_a[W-1]^src_b[W-1]; otherwise latch raw operands with neg_flag=0.
  - acc (2*WIDTH)=0; count=WIDTH; go to RUN.
- RUN, edges E1..E_WIDTH, one per edge:
  - If mplier[0]=1, acc += mcand (zero-extended, shifted by the iteration index).
  - mplier >>= 1; count -= 1.
  - At the edge where count goes 1->0, go to FINISH.
- FINISH, edge E_WIDTH+1:
  - {hi,lo} = neg_flag ? -acc : acc, as 2*WIDTH two's-complement negation.
  - done=1 for exactly that following cycle; go to IDLE.
- Latency:
  - busy=1 in the issue cycle (combinational on start) plus WIDTH+1 registered cycles, i.e. 34 cycles at WIDTH=32.
  - hi/lo hold the new product in the first cycle busy=0.
- Magnitude rule: the most-negative operand 2^(W-1) is exact as an unsigned WIDTH-bit magnitude. No overflow is possible since the product fits in 2*WIDTH bits.
- MTHI/MTLO:
  - Take effect at the edge only when state==IDLE and start=0. Each enable is independent; both may be set in the same cycle.
  - If start=1 in the same cycle, start wins and the writes are dropped.
  - Writes while state!=IDLE are ignored.
- start while state!=IDLE: ignored, and the running operation is undisturbed. The hazard unit stalls issue, so this case is illegal upstream but must be harmless here.
- Pipeline flush: no flush input. A multiply that reached EX always completes.
- HI/LO change only at FINISH->IDLE, on an accepted MTHI/MTLO, or on reset. During RUN they keep their old values.
- reset asserted mid-RUN/FINISH: abort immediately. hi/lo=0, done never pulses, state=IDLE.
- Back-to-back: start may be accepted in the first cycle after FINISH, while done=1. The new operation then begins normally.

Test Plan:
- Unsigned max: reset release, start, sign_mode=0, src_a=src_b=32'hFFFFFFFF -> busy high 34 cycles; then hi=32'hFFFFFFFE, lo=32'h00000001, done pulses exactly 1 cycle.
- Signed mixed: sign_mode=1, src_a=-3, src_b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Same operands with sign_mode=0 -> hi=32'h00000004, lo=32'hFFFFFFF1.
- Most negative: sign_mode=1, src_a=src_b=32'h80000000 -> hi=32'h40000000, lo=0. Also src_a=32'h80000000, src_b=1 -> hi=32'hFFFFFFFF, lo=32'h80000000.
- Write arbitration: in IDLE, wr_hi=1 and wr_data=32'h1234 -> hi=32'h1234 next cycle. Then wr_lo pulsed with 32'hDEAD at the 10th RUN cycle of a 7*6 multiply -> ignored, final hi=0, lo=42. Then start=1 with wr_lo=1 in the same cycle -> lo unchanged by the write.
- Reset mid-op: start 7*6, pull reset low at RUN cycle 15 -> hi=lo=0 asynchronously, done never asserts, busy=0 with start=0. Release, rerun 7*6 -> lo=42 after the full 34-cycle busy window.
- Illegal restart: start pulsed again at RUN cycle 5 with different operands -> ignored; original product is delivered on schedule.

Source files
------------

// File: rtl/mult_div_unit_iter.sv
// Iterative shift-add MULT/MULTU unit with HI/LO registers and MTHI/MTLO write port.
// Product appears on hi/lo WIDTH+2 edges after issue; busy stalls issue upstream meanwhile.
module mult_div_unit_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg_flag;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_res;
    logic               accept;

    // The most-negative value negates to itself, which is already its correct unsigned magnitude.
    assign mag_a   = (sign_mode && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
    assign mag_b   = (sign_mode && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;
    assign acc_res = neg_flag ? (~acc + 1'b1) : acc;

    assign accept = start && (state == IDLE);
    assign busy   = accept || (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_flag <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Issue takes priority; any MTHI/MTLO in the same cycle is dropped.
                        mcand    <= {{WIDTH{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        neg_flag <= sign_mode && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        acc      <= '0;
                        count    <= CNT_W'(WIDTH);
                        state    <= RUN;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - 1'b1;
                    if (count == CNT_W'(1)) state <= FINISH;
                end
                FINISH: begin
                    {hi, lo} <= acc_res;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit_iter.sv
// Self-checking bench for mult_div_unit_iter: directed vectors, corner sequences, random vs. arithmetic model.
module tb_mult_div_unit_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sign_mode;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign_mode (sign_mode),
        .src_a     (src_a),
        .src_b     (src_b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Full-width product from plain arithmetic on the sign- or zero-extended operands.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sm);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sm ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sm ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a multiply now and run to the done cycle.
    // poke_kind: 0 none, 1 MTLO write, 2 illegal restart; applied for one cycle at RUN cycle poke_cyc.
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sm, input int poke_cyc, input int poke_kind);
        logic [63:0] exp;
        logic [63:0] old;
        int cyc;
        exp = ref_mul(a, b, sm);
        old = {hi, lo};
        start = 1'b1; sign_mode = sm; src_a = a; src_b = b;
        wr_hi = 1'b0; wr_lo = 1'b0;
        #1;
        chk({name, "_busy_issue"}, {63'h0, busy}, 64'h1);
        cyc = 0;
        while (cyc < 100) begin
            step();
            cyc++;
            start = 1'b0; wr_lo = 1'b0;
            src_a = a; src_b = b; sign_mode = sm;
            if (!busy) break;
            if (cyc == 20) chk({name, "_hilo_hold"}, {hi, lo}, old);
            if (cyc == poke_cyc && poke_kind == 1) begin
                wr_lo = 1'b1; wr_data = 32'hDEAD;
            end
            if (cyc == poke_cyc && poke_kind == 2) begin
                start = 1'b1; src_a = 32'd99; src_b = 32'hFFFF_FFF0; sign_mode = ~sm;
            end
        end
        chk({name, "_latency"}, 64'(cyc), 64'd34);
        chk({name, "_done"}, {63'h0, done}, 64'h1);
        chk({name, "_prod"}, {hi, lo}, exp);
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b0; start = 1'b0; sign_mode = 1'b0;
        src_a = '0; src_b = '0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;

        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
        vecs.push_back('{32'hFFFF_FFFD, 32'd5,         1'b0, 64'h0000_0004_FFFF_FFF1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
        vecs.push_back('{32'd0,         32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0000});
        vecs.push_back('{32'd7,         32'd6,         1'b0, 64'h0000_0000_0000_002A});

        // Reset state, and busy tracking start while reset is held.
        #2;
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_busy_idle", {63'h0, busy}, 64'h0);
        start = 1'b1;
        #1;
        chk("rst_busy_start", {63'h0, busy}, 64'h1);
        start = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Directed table; the reference model is cross-checked against the hand-computed values.
        foreach (vecs[i]) begin
            chk($sformatf("model_%0d", i), ref_mul(vecs[i].a, vecs[i].b, vecs[i].sm), vecs[i].exp);
            run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, 0, 0);
            step();
            chk($sformatf("vec%0d_done_pulse", i), {63'h0, done}, 64'h0);
        end

        // MTHI in idle, then MTLO during RUN is ignored.
        wr_hi = 1'b1; wr_data = 32'h1234;
        step();
        wr_hi = 1'b0;
        chk("mthi", {32'h0, hi}, 64'h1234);
        chk("mthi_lo_kept", {32'h0, lo}, 64'h2A);
        wr_lo = 1'b1; wr_hi = 1'b1; wr_data = 32'h5555_AAAA;
        step();
        wr_lo = 1'b0; wr_hi = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, 64'h5555_AAAA_5555_AAAA);
        wr_hi = 1'b1; wr_data = 32'h1234;
        step();
        wr_hi = 1'b0;
        run_mul("wr_in_run", 32'd7, 32'd6, 1'b0, 10, 1);
        step();

        // Start beats a simultaneous MTLO.
        start = 1'b1; sign_mode = 1'b0; src_a = 32'd3; src_b = 32'd5;
        wr_lo = 1'b1; wr_data = 32'hDEAD;
        step();
        start = 1'b0; wr_lo = 1'b0;
        chk("start_wins_lo", {32'h0, lo}, 64'h2A);
        for (int k = 0; k < 40 && busy; k++) step();
        chk("start_wins_prod", {hi, lo}, 64'd15);
        step();

        // Asynchronous reset in the middle of RUN.
        start = 1'b1; sign_mode = 1'b0; src_a = 32'd7; src_b = 32'd6;
        step();
        start = 1'b0;
        for (int k = 1; k < 15; k++) step();
        reset = 1'b0;
        #1;
        chk("midrst_hilo", {hi, lo}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (done) seen++;
            end
            chk("midrst_no_done", 64'(seen), 64'h0);
        end
        reset = 1'b1;
        step();
        run_mul("after_rst", 32'd7, 32'd6, 1'b0, 0, 0);
        step();

        // Illegal restart during RUN must not disturb the running op.
        run_mul("restart", 32'd123456, 32'hFFFF_0001, 1'b1, 5, 2);

        // Random back-to-back ops, each issued in the done cycle of the previous one.
        for (int r = 0; r < 24; r++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (r % 6 == 0) ra = 32'h8000_0000;
            if (r % 7 == 1) rb = 32'hFFFF_FFFF;
            run_mul($sformatf("rnd%0d", r), ra, rb, 1'($urandom_range(0, 1)), 0, 0);
        end
        step();
        chk("final_done_low", {63'h0, done}, 64'h0);
        chk("final_busy_low", {63'h0, busy}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
